// File: rtl/bldcm_pwm_capture.sv
// rtl/bldcm_pwm_capture.sv - PWM period / high-time capture in prescaled ticks (optional filter: BLDCM_PWM_CAPTURE_FILTER_EN)
module bldcm_pwm_capture #(
   parameter int pCounterWidth = 32,
   parameter int pNumPrescaler = 32,
   parameter int pFilterLen    = 4
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iEnable,
   input  logic                     iPwm,
   input  logic [5:0]               iPrscSel,
   input  logic [pCounterWidth-1:0] iTimeout,
   output logic [pCounterWidth-1:0] oPeriod,
   output logic [pCounterWidth-1:0] oHighCnt,
   output logic                     oValid,
   output logic                     oOverflow,
   output logic                     oStall
);

   typedef enum logic [1:0] {SEEK, HIGH, LOW, STALL} state_t;

   state_t                     state_q;
   logic                       sync1_q, sync2_q, prev_q;
   logic                       lvl, rise, fall, tick;
   logic [pNumPrescaler-1:0]   prsc_q, prsc_d;
   logic [pCounterWidth-1:0]   per_q, per_d, high_q, high_d, high_lat_q, tick_w;
   logic [pCounterWidth-1:0]   period_q, highcnt_q;
   logic                       per_ovf, high_ovf, timeout_hit;
   logic                       sat_q, valid_q, ovf_q, stall_q;

   // Two-flop synchroniser for the asynchronous PWM input
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= iPwm;
         sync2_q <= sync1_q;
      end
   end

`ifdef BLDCM_PWM_CAPTURE_FILTER_EN
   localparam int FCW = $clog2(pFilterLen + 1);
   logic           flt_q;
   logic [FCW-1:0] flt_cnt_q;

   // Level follows the synced input only after pFilterLen consecutive differing samples
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         flt_q     <= 1'b0;
         flt_cnt_q <= '0;
      end else if (sync2_q == flt_q) begin
         flt_cnt_q <= '0;
      end else if (flt_cnt_q == FCW'(pFilterLen - 1)) begin
         flt_q     <= sync2_q;
         flt_cnt_q <= '0;
      end else begin
         flt_cnt_q <= flt_cnt_q + FCW'(1);
      end
   end

   assign lvl = flt_q;
`else
   assign lvl = sync2_q;
`endif

   // Edge detector history and free-running prescaler
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         prev_q <= 1'b0;
         prsc_q <= '0;
      end else begin
         prev_q <= lvl;
         prsc_q <= prsc_d;
      end
   end

   assign rise   = lvl & ~prev_q;
   assign fall   = ~lvl & prev_q;
   assign prsc_d = prsc_q + {{(pNumPrescaler-1){1'b0}}, 1'b1};

   // Tick on the 0->1 transition of the selected prescaler bit; out-of-range selects tick every clock
   always_comb begin
      tick = 1'b1;
      for (int k = 0; k < pNumPrescaler; k++) begin
         if (iPrscSel == 6'(k + 1)) tick = prsc_d[k] & ~prsc_q[k];
      end
   end

   // Saturating next values of both counters and the stall comparison
   always_comb begin
      tick_w      = {{(pCounterWidth-1){1'b0}}, tick};
      per_ovf     = (&per_q) & tick;
      high_ovf    = (&high_q) & tick;
      per_d       = (&per_q) ? per_q : per_q + tick_w;
      high_d      = (&high_q) ? high_q : high_q + tick_w;
      timeout_hit = (iTimeout != '0) && (per_q == iTimeout);
   end

   // Measurement FSM with registered results
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q    <= SEEK;
         per_q      <= '0;
         high_q     <= '0;
         high_lat_q <= '0;
         sat_q      <= 1'b0;
         period_q   <= '0;
         highcnt_q  <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!iEnable) begin
            state_q <= SEEK;
            per_q   <= '0;
            high_q  <= '0;
            sat_q   <= 1'b0;
            stall_q <= 1'b0;
         end else begin
            case (state_q)
               SEEK: begin
                  per_q  <= '0;
                  high_q <= '0;
                  sat_q  <= 1'b0;
                  if (rise) state_q <= HIGH;
               end
               HIGH: begin
                  per_q  <= per_d;
                  high_q <= high_d;
                  sat_q  <= sat_q | per_ovf | high_ovf;
                  // Timeout takes priority so a coincident fall cannot step past the limit
                  if (timeout_hit) begin
                     state_q <= STALL;
                     stall_q <= 1'b1;
                  end else if (fall) begin
                     state_q    <= LOW;
                     high_lat_q <= high_d;
                  end
               end
               LOW: begin
                  if (rise) begin
                     period_q  <= per_d;
                     highcnt_q <= high_lat_q;
                     valid_q   <= 1'b1;
                     ovf_q     <= sat_q | per_ovf;
                     stall_q   <= 1'b0;
                     per_q     <= '0;
                     high_q    <= '0;
                     sat_q     <= 1'b0;
                     state_q   <= HIGH;
                  end else begin
                     per_q <= per_d;
                     sat_q <= sat_q | per_ovf;
                     if (timeout_hit) begin
                        state_q <= STALL;
                        stall_q <= 1'b1;
                     end
                  end
               end
               STALL: begin
                  per_q  <= '0;
                  high_q <= '0;
                  sat_q  <= 1'b0;
                  if (rise) state_q <= HIGH;
               end
               default: state_q <= SEEK;
            endcase
         end
      end
   end

   assign oPeriod   = period_q;
   assign oHighCnt  = highcnt_q;
   assign oValid    = valid_q;
   assign oOverflow = ovf_q;
   assign oStall    = stall_q;

endmodule

// File: tb/tb_bldcm_pwm_capture.sv
// tb/tb_bldcm_pwm_capture.sv - self-checking bench for bldcm_pwm_capture
module tb_bldcm_pwm_capture;

   localparam int CW = 8;

   logic          clk, rst, en, pwm, vld, ovf, stl;
   logic [5:0]    sel;
   logic [CW-1:0] tmo, per, hi;

   typedef struct {int per; int hi; bit ovf; bit stall; int cyc;} rec_t;
   rec_t q[$];
   int   cyc;
   int   n_chk, n_fail;

   bldcm_pwm_capture #(.pCounterWidth(CW)) dut (
      .iClock(clk), .iReset(rst), .iEnable(en), .iPwm(pwm), .iPrscSel(sel),
      .iTimeout(tmo), .oPeriod(per), .oHighCnt(hi), .oValid(vld),
      .oOverflow(ovf), .oStall(stl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Every published result is recorded on the falling edge
   always @(negedge clk) begin
      if (vld === 1'b1) begin
         rec_t r;
         r.per = int'(per); r.hi = int'(hi); r.ovf = ovf; r.stall = stl; r.cyc = cyc;
         q.push_back(r);
      end
   end

   // Reference: ticks of a clock-aligned span that is a multiple of 2^s, saturated to the counter width
   function automatic int ticks(int clks, int s);
      return clks >> s;
   endfunction
   function automatic int satv(int t);
      return (t > 255) ? 255 : t;
   endfunction

   task automatic clks(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rearm();
      pwm = 1'b0; en = 1'b0;
      clks(4);
      en = 1'b1;
      clks(2);
      q.delete();
   endtask

   task automatic do_period(int p, int h);
      pwm = 1'b1; clks(h);
      pwm = 1'b0; clks(p - h);
   endtask

   // n full periods followed by one more rise: n+1 rises, so n results expected
   task automatic run_wave(int p, int h, int n);
      for (int i = 0; i < n; i++) do_period(p, h);
      pwm = 1'b1;
      clks(12);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; pwm = 1'b0; sel = 6'd0; tmo = '0;
      clks(3);
      n_chk++; if (per !== 8'd0) begin n_fail++; $display("FAIL reset_period: got %0d expected 0", per); end
      n_chk++; if (hi !== 8'd0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", hi); end
      n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", vld); end
      n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      n_chk++; if (stl !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stl); end
      rst = 1'b0;
      clks(2);
   endtask

   task automatic test_basic();
      rearm(); sel = 6'd0; tmo = '0;
      run_wave(100, 30, 5);
      n_chk++; if (q.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d expected 5", q.size()); end
      for (int i = 0; i < q.size() && i < 5; i++) begin
         n_chk++; if (q[i].per !== 100 || q[i].hi !== 30 || q[i].ovf !== 1'b0) begin
            n_fail++; $display("FAIL basic_result[%0d]: got %0d/%0d/%b expected 100/30/0", i, q[i].per, q[i].hi, q[i].ovf);
         end
         if (i > 0) begin
            n_chk++; if (q[i].cyc - q[i-1].cyc !== 100) begin
               n_fail++; $display("FAIL basic_interval[%0d]: got %0d expected 100", i, q[i].cyc - q[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_prescale();
      rearm(); sel = 6'd2; tmo = '0;
      run_wave(400, 100, 3);
      n_chk++; if (q.size() !== 3) begin n_fail++; $display("FAIL prsc_count: got %0d expected 3", q.size()); end
      for (int i = 0; i < q.size() && i < 3; i++) begin
         n_chk++; if (q[i].per !== 100 || q[i].hi !== 25) begin
            n_fail++; $display("FAIL prsc_result[%0d]: got %0d/%0d expected 100/25", i, q[i].per, q[i].hi);
         end
      end
      sel = 6'd0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int s, pt, ht, ep, eh;
         bit eo;
         s  = int'($urandom_range(0, 2));
         pt = int'($urandom_range(12, 300));
         ht = int'($urandom_range(6, pt - 6));
         rearm(); sel = 6'(s); tmo = '0;
         run_wave(pt << s, ht << s, 2);
         ep = satv(ticks(pt << s, s)); eh = satv(ticks(ht << s, s)); eo = (ticks(pt << s, s) > 255);
         n_chk++; if (q.size() !== 2) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected 2", it, q.size()); end
         for (int i = 0; i < q.size() && i < 2; i++) begin
            n_chk++; if (q[i].per !== ep || q[i].hi !== eh || q[i].ovf !== eo) begin
               n_fail++; $display("FAIL rand_result[%0d.%0d] sel=%0d: got %0d/%0d/%b expected %0d/%0d/%b",
                                  it, i, s, q[i].per, q[i].hi, q[i].ovf, ep, eh, eo);
            end
         end
      end
      sel = 6'd0;
   endtask

   task automatic test_stall();
      rearm(); sel = 6'd0; tmo = 8'd50;
      run_wave(40, 15, 1);
      clks(3); pwm = 1'b0; clks(30);
      n_chk++; if (stl !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b expected 0", stl); end
      clks(20);
      n_chk++; if (stl !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %b expected 1", stl); end
      clks(50);
      n_chk++; if (stl !== 1'b1 || per !== 8'd40) begin
         n_fail++; $display("FAIL stall_hold: got stall=%b per=%0d expected 1/40", stl, per);
      end
      run_wave(40, 15, 1);
      n_chk++; if (q.size() !== 2) begin n_fail++; $display("FAIL stall_resume_count: got %0d expected 2", q.size()); end
      if (q.size() >= 2) begin
         n_chk++; if (q[1].per !== 40 || q[1].hi !== 15 || q[1].stall !== 1'b0) begin
            n_fail++; $display("FAIL stall_resume: got %0d/%0d stall=%b expected 40/15/0", q[1].per, q[1].hi, q[1].stall);
         end
      end
      tmo = '0;
   endtask

   task automatic test_overflow();
      int plist[3] = '{300, 255, 256};
      int hlist[3] = '{280, 100, 100};
      for (int k = 0; k < 3; k++) begin
         int ep, eh;
         bit eo;
         rearm(); sel = 6'd0; tmo = '0;
         run_wave(plist[k], hlist[k], 2);
         ep = satv(plist[k]); eh = satv(hlist[k]); eo = (plist[k] > 255);
         n_chk++; if (q.size() !== 2) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d expected 2", k, q.size()); end
         for (int i = 0; i < q.size() && i < 2; i++) begin
            n_chk++; if (q[i].per !== ep || q[i].hi !== eh || q[i].ovf !== eo) begin
               n_fail++; $display("FAIL ovf_result[%0d.%0d]: got %0d/%0d/%b expected %0d/%0d/%b",
                                  k, i, q[i].per, q[i].hi, q[i].ovf, ep, eh, eo);
            end
         end
      end
   endtask

   task automatic test_reset_enable();
      rearm(); sel = 6'd0; tmo = '0;
      run_wave(60, 20, 1);
      n_chk++; if (q.size() !== 1) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 1", q.size()); end
      rst = 1'b1;
      #1;
      n_chk++; if (per !== 8'd0 || hi !== 8'd0 || vld !== 1'b0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL rst_async: got %0d/%0d/%b/%b expected 0/0/0/0", per, hi, vld, ovf);
      end
      pwm = 1'b0;
      clks(2); rst = 1'b0; clks(2);
      q.delete();
      run_wave(60, 20, 1);
      n_chk++; if (q.size() !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 1", q.size()); end
      if (q.size() >= 1) begin
         n_chk++; if (q[0].per !== 60 || q[0].hi !== 20) begin
            n_fail++; $display("FAIL rst_after_result: got %0d/%0d expected 60/20", q[0].per, q[0].hi);
         end
      end
      clks(8); pwm = 1'b0; clks(20);
      q.delete();
      en = 1'b0;
      clks(5);
      n_chk++; if (per !== 8'd60 || hi !== 8'd20 || vld !== 1'b0) begin
         n_fail++; $display("FAIL en_hold: got %0d/%0d/%b expected 60/20/0", per, hi, vld);
      end
      en = 1'b1;
      clks(10);
      run_wave(60, 20, 1);
      n_chk++; if (q.size() !== 1) begin n_fail++; $display("FAIL en_after_count: got %0d expected 1", q.size()); end
      if (q.size() >= 1) begin
         n_chk++; if (q[0].per !== 60 || q[0].hi !== 20) begin
            n_fail++; $display("FAIL en_after_result: got %0d/%0d expected 60/20", q[0].per, q[0].hi);
         end
      end
   endtask

   task automatic test_glitch();
      rearm(); sel = 6'd0; tmo = '0;
      pwm = 1'b1; clks(2);
      pwm = 1'b0; clks(50);
      pwm = 1'b1; clks(12);
`ifdef BLDCM_PWM_CAPTURE_FILTER_EN
      n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL glitch_filtered: got %0d results expected 0", q.size()); end
`else
      n_chk++; if (q.size() !== 1) begin n_fail++; $display("FAIL glitch_count: got %0d expected 1", q.size()); end
      if (q.size() >= 1) begin
         n_chk++; if (q[0].hi !== 2 || q[0].per !== 52) begin
            n_fail++; $display("FAIL glitch_result: got %0d/%0d expected 52/2", q[0].per, q[0].hi);
         end
      end
`endif
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0;
      test_reset();
      test_basic();
      test_prescale();
      test_random();
      test_stall();
      test_overflow();
      test_reset_enable();
      test_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
